// File: rtl/i2c_master_top.sv
// I2C master: START, 7-bit address + R/W, write/read bytes with ACK,
// then STOP or repeated START. Open-drain style drive (1 = release).
module i2c_master_top (
    input  logic       i2c_core_clock_i,
    input  logic       reset_bit_i,
    input  logic       enable_bit_i,
    input  logic [7:0] data_i,
    input  logic [7:0] addr_rw_i,
    input  logic [7:0] prescaler_i,
    input  logic       repeat_start_bit_i,
    input  logic       trans_fifo_empty_i,
    input  logic       rev_fifo_full_i,
    input  logic [7:0] state_done_time_i,
    input  logic       ack_bit_i,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       scl_o
);

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_ACK,
        STOP,
        REPEAT_START
    } state_t;

    state_t     state;
    state_t     end_st;
    logic [7:0] presc_cnt;
    logic [7:0] hold_cnt;
    logic [7:0] addr_q;
    logic [7:0] data_q;
    logic [7:0] rx_shift;
    logic [7:0] cur_byte;
    logic [7:0] presc_val;
    logic [7:0] hold_val;
    logic [2:0] bit_cnt;
    logic [1:0] phase;
    logic       ack_smp;
    logic       bit_state;
    logic       tick;
    logic       rise_tick;
    logic       fall_tick;
    logic       hold_done;

    assign presc_val = (prescaler_i == 8'd0) ? 8'd1 : prescaler_i;
    assign hold_val  = (state_done_time_i == 8'd0) ? 8'd1 : state_done_time_i;
    assign hold_done = (hold_cnt <= 8'd1);
    assign tick      = bit_state && (presc_cnt <= 8'd1);
    assign rise_tick = tick && !scl_o;
    assign fall_tick = tick && scl_o;
    assign cur_byte  = (state == ADDR) ? addr_q : data_q;
    assign end_st    = repeat_start_bit_i ? REPEAT_START : STOP;

    // SCL toggles only in the byte/ACK states
    always_comb begin
        bit_state = 1'b0;
        unique case (state)
            ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK: bit_state = 1'b1;
            default: bit_state = 1'b0;
        endcase
    end

    // Prescaler: preloaded outside the bit states, reloaded on each tick
    always_ff @(posedge i2c_core_clock_i or negedge reset_bit_i) begin
        if (!reset_bit_i) begin
            presc_cnt <= 8'd0;
        end else if (!bit_state || tick) begin
            presc_cnt <= presc_val;
        end else begin
            presc_cnt <= presc_cnt - 8'd1;
        end
    end

    // Main transfer FSM with registered SCL/SDA drive
    always_ff @(posedge i2c_core_clock_i or negedge reset_bit_i) begin
        if (!reset_bit_i) begin
            state    <= IDLE;
            scl_o    <= 1'b1;
            sda_o    <= 1'b1;
            hold_cnt <= 8'd0;
            bit_cnt  <= 3'd0;
            phase    <= 2'd0;
            addr_q   <= 8'd0;
            data_q   <= 8'd0;
            rx_shift <= 8'd0;
            ack_smp  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    scl_o <= 1'b1;
                    sda_o <= 1'b1;
                    if (enable_bit_i) begin
                        addr_q   <= addr_rw_i;
                        sda_o    <= 1'b0;
                        hold_cnt <= hold_val;
                        state    <= START;
                    end
                end
                START: begin
                    if (hold_done) begin
                        scl_o   <= 1'b0;
                        sda_o   <= addr_q[7];
                        bit_cnt <= 3'd0;
                        state   <= ADDR;
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end
                end
                ADDR, WRITE: begin
                    if (tick) begin
                        scl_o <= !scl_o;
                    end
                    if (fall_tick) begin
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= 3'd0;
                            sda_o   <= 1'b1;
                            state   <= (state == ADDR) ? ADDR_ACK : WRITE_ACK;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            sda_o   <= cur_byte[3'd6 - bit_cnt];
                        end
                    end
                end
                ADDR_ACK, WRITE_ACK: begin
                    if (tick) begin
                        scl_o <= !scl_o;
                    end
                    if (rise_tick) begin
                        ack_smp <= sda_i;
                    end
                    if (fall_tick) begin
                        hold_cnt <= hold_val;
                        phase    <= 2'd0;
                        if (ack_smp) begin
                            sda_o <= 1'b0;
                            state <= STOP;
                        end else if (state == ADDR_ACK && addr_q[0]) begin
                            sda_o <= 1'b1;
                            state <= READ;
                        end else if (!trans_fifo_empty_i) begin
                            data_q <= data_i;
                            sda_o  <= data_i[7];
                            state  <= WRITE;
                        end else begin
                            sda_o <= repeat_start_bit_i;
                            state <= end_st;
                        end
                    end
                end
                READ: begin
                    sda_o <= 1'b1;
                    if (tick) begin
                        scl_o <= !scl_o;
                    end
                    if (rise_tick) begin
                        rx_shift <= {rx_shift[6:0], sda_i};
                    end
                    if (fall_tick) begin
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= 3'd0;
                            sda_o   <= ack_bit_i;
                            state   <= READ_ACK;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                READ_ACK: begin
                    if (tick) begin
                        scl_o <= !scl_o;
                    end
                    if (fall_tick) begin
                        hold_cnt <= hold_val;
                        phase    <= 2'd0;
                        if (!ack_bit_i && !rev_fifo_full_i) begin
                            sda_o <= 1'b1;
                            state <= READ;
                        end else begin
                            sda_o <= repeat_start_bit_i;
                            state <= end_st;
                        end
                    end
                end
                STOP: begin
                    if (!hold_done) begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end else begin
                        hold_cnt <= hold_val;
                        unique case (phase)
                            2'd0: begin
                                scl_o <= 1'b1;
                                phase <= 2'd1;
                            end
                            2'd1: begin
                                sda_o <= 1'b1;
                                phase <= 2'd2;
                            end
                            default: begin
                                phase <= 2'd0;
                                state <= IDLE;
                            end
                        endcase
                    end
                end
                REPEAT_START: begin
                    if (!hold_done) begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end else begin
                        hold_cnt <= hold_val;
                        if (phase == 2'd0) begin
                            scl_o <= 1'b1;
                            phase <= 2'd1;
                        end else begin
                            phase  <= 2'd0;
                            addr_q <= addr_rw_i;
                            sda_o  <= 1'b0;
                            state  <= START;
                        end
                    end
                end
                default: begin
                    scl_o <= 1'b1;
                    sda_o <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_top.sv
// Self-checking bench: bus-level monitor decodes START/STOP/bits and
// compares them with an expected event queue built from each transaction.
module tb_i2c_master_top;

    localparam int EV_S = 2;
    localparam int EV_P = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable_bit_i;
    logic [7:0] data_i;
    logic [7:0] addr_rw_i;
    logic [7:0] prescaler_i;
    logic       repeat_start_bit_i;
    logic       trans_fifo_empty_i;
    logic       rev_fifo_full_i;
    logic [7:0] state_done_time_i;
    logic       ack_bit_i;
    logic       sda_i;
    logic       sda_o;
    logic       scl_o;

    i2c_master_top dut (
        .i2c_core_clock_i   (clk),
        .reset_bit_i        (rst_n),
        .enable_bit_i       (enable_bit_i),
        .data_i             (data_i),
        .addr_rw_i          (addr_rw_i),
        .prescaler_i        (prescaler_i),
        .repeat_start_bit_i (repeat_start_bit_i),
        .trans_fifo_empty_i (trans_fifo_empty_i),
        .rev_fifo_full_i    (rev_fifo_full_i),
        .state_done_time_i  (state_done_time_i),
        .ack_bit_i          (ack_bit_i),
        .sda_i              (sda_i),
        .sda_o              (sda_o),
        .scl_o              (scl_o)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         exp_q[$];
    logic [7:0] wq[$];
    int         slv[64];
    int         acks[8];
    bit         rd_mode;
    bit         mon_on;
    int         exp_per;
    int         exp_hold;
    int         start_cnt = 0;
    int         stop_cnt = 0;
    int         cyc = 0;
    logic       p_scl;
    logic       p_sda;
    int         pend;
    bit         pend_v;
    int         rise_cyc;
    int         prev_rise;
    bit         prev_v;
    int         start_cyc;
    bit         start_v;
    int         idx;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_ev(input int ev);
        int e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL bus_event: got %0d expected none (t=%0t)", ev, $time);
        end else begin
            e = exp_q.pop_front();
            chk("bus_event", ev, e);
        end
    endtask

    task automatic refresh_fifo();
        trans_fifo_empty_i = (wq.size() == 0);
        data_i = (wq.size() > 0) ? wq[0] : 8'h00;
    endtask

    // Bus monitor and slave model, sampled on the falling clock edge
    initial begin
        p_scl = 1'b1;
        p_sda = 1'b1;
        pend_v = 0;
        prev_v = 0;
        start_v = 0;
        idx = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_on) begin
                if (p_scl && scl_o && (p_sda != sda_o)) begin
                    pend_v = 0;
                    prev_v = 0;
                    if (sda_o) begin
                        check_ev(EV_P);
                        stop_cnt++;
                        chk("stop_hold", cyc - rise_cyc, exp_hold);
                    end else begin
                        check_ev(EV_S);
                        start_cnt++;
                        start_cyc = cyc;
                        start_v = 1;
                        idx = 0;
                        sda_i = slv[0][0];
                    end
                end else if (!p_scl && scl_o) begin
                    pend = int'(sda_o);
                    pend_v = 1;
                    rise_cyc = cyc;
                end else if (p_scl && !scl_o) begin
                    if (start_v) begin
                        chk("start_hold", cyc - start_cyc, exp_hold);
                        start_v = 0;
                    end
                    if (pend_v) begin
                        check_ev(pend);
                        if (prev_v) chk("scl_period", rise_cyc - prev_rise, exp_per);
                        prev_rise = rise_cyc;
                        prev_v = 1;
                        pend_v = 0;
                        if (idx % 9 == 8) begin
                            if (rd_mode) begin
                                ack_bit_i = acks[(idx / 9) % 8][0];
                            end else if (slv[idx] == 0 && wq.size() > 0) begin
                                void'(wq.pop_front());
                                refresh_fifo();
                            end
                        end
                        if (idx < 63) idx++;
                        sda_i = slv[idx][0];
                    end
                end
            end
            p_scl = scl_o;
            p_sda = sda_o;
        end
    end

    task automatic push_byte(input logic [7:0] b);
        for (int j = 7; j >= 0; j--) exp_q.push_back(int'(b[j]));
    endtask

    task automatic wait_ev(input bit is_stop, input int target);
        bit hit = 0;
        for (int n = 0; n < 20000 && !hit; n++) begin
            @(negedge clk);
            hit = is_stop ? (stop_cnt >= target) : (start_cnt >= target);
        end
        if (!hit) chk(is_stop ? "stop_timeout" : "start_timeout", 0, 1);
    endtask

    // Builds the expected bus events from the transaction description
    task automatic run_txn(input logic [7:0] addr, input bit nack,
                           input int nb, input bit full, input bit rs,
                           input logic [7:0] addr2, input logic [7:0] d0);
        int         s0;
        int         p0;
        int         ak;
        logic [7:0] b;
        exp_per  = 2 * ((prescaler_i == 0) ? 1 : int'(prescaler_i));
        exp_hold = (state_done_time_i == 0) ? 1 : int'(state_done_time_i);
        for (int i = 0; i < 64; i++) slv[i] = 1;
        for (int i = 0; i < 8; i++) acks[i] = 1;
        wq.delete();
        exp_q.delete();
        rd_mode = addr[0];
        slv[8] = nack ? 1 : 0;
        exp_q.push_back(EV_S);
        push_byte(addr);
        exp_q.push_back(1);
        if (!nack && !addr[0]) begin
            for (int k = 0; k < nb; k++) begin
                b = (k == 0) ? d0 : 8'($urandom);
                wq.push_back(b);
                push_byte(b);
                exp_q.push_back(1);
                slv[17 + 9 * k] = 0;
            end
        end
        if (!nack && addr[0]) begin
            for (int k = 0; k < nb; k++) begin
                b = (k == 0) ? d0 : 8'($urandom);
                for (int j = 0; j < 8; j++) slv[9 + 9 * k + j] = int'(b[7 - j]);
                for (int j = 0; j < 8; j++) exp_q.push_back(1);
                ak = (k == nb - 1) ? 1 : 0;
                acks[k] = ak;
                exp_q.push_back(ak);
                if (ak == 1 || full) break;
            end
        end
        if (rs) begin
            exp_q.push_back(EV_S);
            push_byte(addr2);
            exp_q.push_back(1);
        end
        exp_q.push_back(EV_P);
        refresh_fifo();
        addr_rw_i = addr;
        ack_bit_i = acks[0][0];
        rev_fifo_full_i = full;
        repeat_start_bit_i = rs;
        s0 = start_cnt;
        p0 = stop_cnt;
        enable_bit_i = 1'b1;
        @(negedge clk);
        enable_bit_i = 1'b0;
        if (rs) begin
            wait_ev(1'b0, s0 + 1);
            addr_rw_i = addr2;
            wait_ev(1'b0, s0 + 2);
            repeat_start_bit_i = 1'b0;
        end
        wait_ev(1'b1, p0 + 1);
        repeat (exp_hold + 3) @(negedge clk);
        chk("idle_lines", int'({sda_o, scl_o}), 3);
        chk("events_left", exp_q.size(), 0);
    endtask

    initial begin
        bit idle_ok;
        mon_on = 0;
        rst_n = 1'b0;
        enable_bit_i = 1'b0;
        data_i = 8'h00;
        addr_rw_i = 8'h00;
        prescaler_i = 8'd4;
        repeat_start_bit_i = 1'b0;
        trans_fifo_empty_i = 1'b1;
        rev_fifo_full_i = 1'b0;
        state_done_time_i = 8'd4;
        ack_bit_i = 1'b1;
        sda_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_sda", int'(sda_o), 1);
        chk("reset_scl", int'(scl_o), 1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        mon_on = 1;

        run_txn(8'hAA, 0, 1, 0, 0, 8'h00, 8'h14);
        run_txn(8'hAA, 1, 1, 0, 0, 8'h00, 8'h14);
        run_txn(8'hAB, 0, 2, 0, 0, 8'h00, 8'hC3);
        run_txn(8'h50, 0, 0, 0, 1, 8'h52, 8'h00);
        prescaler_i = 8'd0;
        state_done_time_i = 8'd0;
        run_txn(8'h3C, 0, 2, 0, 0, 8'h00, 8'h5A);

        prescaler_i = 8'd4;
        state_done_time_i = 8'd4;
        mon_on = 0;
        addr_rw_i = 8'hA0;
        trans_fifo_empty_i = 1'b1;
        enable_bit_i = 1'b1;
        @(negedge clk);
        enable_bit_i = 1'b0;
        repeat (30) @(negedge clk);
        for (int n = 0; n < 20 && scl_o; n++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_sda", int'(sda_o), 1);
        chk("midrst_scl", int'(scl_o), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_ok = 1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (!sda_o || !scl_o) idle_ok = 0;
        end
        chk("post_reset_idle", int'(idle_ok), 1);
        exp_q.delete();
        pend_v = 0;
        prev_v = 0;
        start_v = 0;
        mon_on = 1;
        run_txn(8'h12, 0, 1, 0, 0, 8'h00, 8'h81);

        for (int t = 0; t < 12; t++) begin
            logic [7:0] a;
            bit         rd;
            prescaler_i = 8'($urandom_range(0, 6));
            state_done_time_i = 8'($urandom_range(0, 6));
            a = 8'($urandom);
            rd = a[0];
            run_txn(a, ($urandom % 4) == 0,
                    rd ? $urandom_range(1, 3) : $urandom_range(0, 3),
                    rd && (($urandom % 4) == 0), 0, 8'h00, 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
